// File: rtl/ccff_chain_loader.sv
// ============================================================================
//  Module   : ccff_chain_loader
//  Purpose  : Loads a byte-wide bitstream into a configuration-flop scan chain,
//             prefixed by an 8-bit marker that is verified as it exits the tail.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader #(
    parameter int         CHAIN_LEN = 64,
    parameter logic [7:0] MARKER    = 8'hA5
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       shift_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int             CW       = $clog2(CHAIN_LEN + 9);
    localparam logic [CW-1:0]  C_CHK_LO = CW'(CHAIN_LEN);
    localparam logic [CW-1:0]  C_LAST   = CW'(CHAIN_LEN + 7);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MARKER = 3'd1,
        S_FETCH  = 3'd2,
        S_SHIFT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    word_q, word_d;
    logic          error_q, error_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          shift_q, shift_d;
    logic          head_q, head_d;

    logic          w_in_window;
    logic [2:0]    w_chk_idx;

    // c counts shifts already completed, so c = N+j means marker bit j is at the tail
    assign w_in_window = (c_q >= C_CHK_LO) && (c_q <= C_LAST);
    assign w_chk_idx   = 3'(c_q - C_CHK_LO);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        bit_d   = bit_q;
        word_d  = word_q;
        error_d = error_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_MARKER;
                    c_d     = '0;
                    bit_d   = '0;
                    error_d = 1'b0;
                end
            end
            S_MARKER: begin
                c_d   = c_q + CW'(1);
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cfg_valid) begin
                    word_d  = cfg_data;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                c_d   = c_q + CW'(1);
                bit_d = bit_q + 3'd1;
                if (c_q == C_LAST) begin
                    state_d = S_DONE;
                end else if (bit_q == 3'd7) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q == S_MARKER || state_q == S_SHIFT) && w_in_window &&
            (ccff_tail != MARKER[w_chk_idx])) begin
            error_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state register
    always_comb begin
        busy_d  = (state_d == S_MARKER) || (state_d == S_FETCH) || (state_d == S_SHIFT);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_FETCH);
        shift_d = (state_d == S_MARKER) || (state_d == S_SHIFT);
        head_d  = 1'b0;
        case (state_d)
            S_MARKER: head_d = MARKER[bit_d];
            S_SHIFT:  head_d = word_d[bit_d];
            default:  head_d = 1'b0;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            shift_q <= 1'b0;
            head_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            shift_q <= shift_d;
            head_q  <= head_d;
        end
    end

    assign cfg_ready = ready_q;
    assign shift_en  = shift_q;
    assign ccff_head = head_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
//  Module   : tb_ccff_chain_loader
//  Purpose  : Randomized self-checking bench with chain models for N=64 and N=61.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

    localparam logic [7:0] C_MARKER = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_start [2];
    logic [7:0]  r_data  [2];
    logic        r_valid [2];
    logic        w_ready [2];
    logic        w_head  [2];
    logic        w_tail  [2];
    logic        w_shift [2];
    logic        w_busy  [2];
    logic        w_done  [2];
    logic        w_error [2];

    logic [79:0] r_chain [2];
    int          r_len   [2];
    logic        r_stuck [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(64), .MARKER(C_MARKER)) u_dut64 (
        .prog_clk(clk), .pReset(rst), .start(r_start[0]),
        .cfg_data(r_data[0]), .cfg_valid(r_valid[0]), .cfg_ready(w_ready[0]),
        .ccff_head(w_head[0]), .ccff_tail(w_tail[0]), .shift_en(w_shift[0]),
        .busy(w_busy[0]), .done(w_done[0]), .error(w_error[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(61), .MARKER(C_MARKER)) u_dut61 (
        .prog_clk(clk), .pReset(rst), .start(r_start[1]),
        .cfg_data(r_data[1]), .cfg_valid(r_valid[1]), .cfg_ready(w_ready[1]),
        .ccff_head(w_head[1]), .ccff_tail(w_tail[1]), .shift_en(w_shift[1]),
        .busy(w_busy[1]), .done(w_done[1]), .error(w_error[1])
    );

    // Behavioural scan chains: flop 0 takes the head, tail is flop len-1
    assign w_tail[0] = r_stuck[0] ? 1'b0 : r_chain[0][r_len[0]-1];
    assign w_tail[1] = r_stuck[1] ? 1'b0 : r_chain[1][r_len[1]-1];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (w_shift[k]) r_chain[k] <= {r_chain[k][78:0], w_head[k]};
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs(input int s);
        return {w_ready[s], w_head[s], w_shift[s], w_busy[s], w_done[s], w_error[s]};
    endfunction

    // mode: 0 random words, 1 ramp 0x01.., 2 all 0xFF
    task automatic run_load(input int sel, input int mode, input int stall_max,
                            input bit stall_rand, input int start_mid, input int rst_at,
                            input int len, input bit stk);
        int          n, nw, wi, stall_left, total_stall, shifts, edges, bad_head;
        logic [7:0]  wd [8];
        logic [79:0] s, old, obs;
        logic [63:0] got_v, exp_v;
        logic        exp_err, t, sh, hd, acc;

        n  = sel ? 61 : 64;
        nw = (n + 7) / 8;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       wd[i] = 8'($urandom);
                1:       wd[i] = 8'(i + 1);
                default: wd[i] = 8'hFF;
            endcase
        end
        s = '0;
        for (int j = 0; j < 8; j++) s[j] = C_MARKER[j];
        for (int i = 0; i < n; i++) s[8+i] = wd[i/8][i%8];

        r_len[sel]   = len;
        r_stuck[sel] = stk;
        old          = r_chain[sel];
        exp_err      = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (stk)                t = 1'b0;
            else if (n + j >= len)  t = s[n+j-len];
            else                    t = old[len-1-(n+j)];
            if (t != C_MARKER[j]) exp_err = 1'b1;
        end

        @(negedge clk);
        r_start[sel] = 1'b1;
        @(posedge clk);
        #1;
        check_val("start_state", 64'({w_busy[sel], w_done[sel], w_error[sel]}), 64'b100);
        @(negedge clk);
        r_start[sel] = 1'b0;

        wi = 0; edges = 0; shifts = 0; bad_head = 0; total_stall = 0; obs = '0;
        stall_left = stall_rand ? int'($urandom_range(stall_max, 0)) : stall_max;
        while (edges < 600) begin
            if (edges != 0) @(negedge clk);
            if (w_ready[sel] && wi < nw) begin
                if (stall_left > 0) begin
                    r_valid[sel] = 1'b0;
                    stall_left--;
                    total_stall++;
                end else begin
                    r_valid[sel] = 1'b1;
                    r_data[sel]  = wd[wi];
                end
            end else begin
                r_valid[sel] = 1'b0;
                r_data[sel]  = 8'($urandom);
            end
            if (!w_shift[sel] && w_head[sel]) bad_head++;
            if (w_shift[sel] && w_ready[sel]) bad_head++;
            r_start[sel] = (start_mid != 0) && (shifts == start_mid);
            sh  = w_shift[sel];
            hd  = w_head[sel];
            acc = r_valid[sel] && w_ready[sel];
            @(posedge clk);
            edges++;
            if (sh) begin
                obs[shifts] = hd;
                shifts++;
            end
            if (acc) begin
                wi++;
                stall_left = stall_rand ? int'($urandom_range(stall_max, 0)) : stall_max;
            end
            if (rst_at != 0 && shifts == rst_at) begin
                #2 rst = 1'b1;
                #1 check_val("reset_outputs", 64'(outs(sel)), 64'd0);
                @(negedge clk);
                rst          = 1'b0;
                r_valid[sel] = 1'b0;
                r_start[sel] = 1'b0;
                repeat (3) @(posedge clk);
                #1 check_val("idle_after_reset", 64'(outs(sel)), 64'd0);
                return;
            end
            #1;
            if (w_done[sel]) break;
        end
        r_valid[sel] = 1'b0;
        r_start[sel] = 1'b0;

        check_val("done_reached", 64'(w_done[sel]), 64'd1);
        check_val("done_edge", 64'(edges), 64'(n + 8 + nw + total_stall));
        check_val("shift_count", 64'(shifts), 64'(n + 8));
        check_val("marker_head", 64'(obs[7:0]), 64'(C_MARKER));
        got_v = '0; exp_v = '0;
        for (int i = 0; i < n; i++) begin
            got_v[i] = obs[8+i];
            exp_v[i] = wd[i/8][i%8];
        end
        check_val("data_head", got_v, exp_v);
        check_val("head_idle_zero", 64'(bad_head), 64'd0);
        check_val("error_flag", 64'(w_error[sel]), 64'(exp_err));
        check_val("end_state", 64'({w_busy[sel], w_ready[sel], w_shift[sel]}), 64'd0);
        if (len == n) begin
            got_v = '0; exp_v = '0;
            for (int f = 0; f < n; f++) got_v[f] = r_chain[sel][f];
            for (int i = 0; i < n; i++) exp_v[n-1-i] = wd[i/8][i%8];
            check_val("chain_contents", got_v, exp_v);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            r_start[k] = 1'b0;
            r_valid[k] = 1'b0;
            r_data[k]  = 8'h00;
            r_chain[k] = '0;
            r_stuck[k] = 1'b0;
        end
        r_len[0] = 64;
        r_len[1] = 61;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_state64", 64'(outs(0)), 64'd0);
        check_val("reset_state61", 64'(outs(1)), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_load(0, 1, 0, 1'b0, 0, 0, 64, 1'b0);   // ramp words, no stalls
        run_load(0, 0, 0, 1'b0, 0, 0, 64, 1'b1);   // tail stuck at 0
        run_load(0, 1, 0, 1'b0, 0, 0, 64, 1'b0);   // restart from an errored DONE
        run_load(0, 0, 0, 1'b0, 0, 0, 65, 1'b0);   // chain one flop too long
        run_load(0, 1, 5, 1'b0, 0, 0, 64, 1'b0);   // 5-cycle stall before each word
        run_load(1, 2, 0, 1'b0, 0, 0, 61, 1'b0);   // N=61, all ones
        run_load(0, 0, 0, 1'b0, 0, 30, 64, 1'b0);  // reset at the 30th shift
        run_load(0, 0, 0, 1'b0, 0, 0, 64, 1'b0);
        run_load(0, 0, 2, 1'b1, 20, 0, 64, 1'b0);  // start pulsed mid-load
        for (int r = 0; r < 8; r++) begin
            run_load(r % 2, 0, 4, 1'b1, 0, 0, (r % 2 == 1) ? 61 : 64, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequencer that loads a configuration-chain bitstream into the fabric's scan chain of `sky130_osu_sc_18T_hs__dffr_1` configuration flops. It sits between a byte-wide bitstream source (valid/ready) and the chain's `ccff_head`/`ccff_tail` pins, and drives the chain shift enable. Before the data it shifts an 8-bit integrity marker, then checks that marker as it falls out of `ccff_tail`, so a broken or mis-sized chain is flagged.

## Interface
- `CHAIN_LEN`, default 64: number of flops in the chain (N); must be ≥ 1.
- `MARKER`, default 8'hA5: integrity marker, shifted LSB first.
- `prog_clk`  in  1  programming clock; all state changes on its rising edge.
- `pReset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a load; sampled in IDLE or DONE only.
- `cfg_data`  in  8  bitstream word, LSB shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  word accepted on edge with `cfg_valid & cfg_ready`.
- `ccff_head`  out  1  serial bit into chain flop 0.
- `ccff_tail`  in  1  output of chain flop N-1.
- `shift_en`  out  1  chain captures `ccff_head` on edges where high.
- `busy`  out  1  load in progress.
- `done`  out  1  load complete (level).
- `error`  out  1  marker mismatch seen in last load (valid when `done`=1).

## Operation
- All outputs reset to 0; state IDLE; counters and word register cleared.
- States: IDLE → MARKER → FETCH ⇄ SHIFT → DONE. The flow returns to MARKER from IDLE/DONE on `start`.
- IDLE/DONE: `start`=1 goes to MARKER. It also clears `done`, `error` and the shift count c, and sets `busy`.
- MARKER: 8 cycles with `shift_en`=1, `ccff_head`=MARKER[j] on shift j (j=0..7). It then goes to FETCH.
- FETCH: `cfg_ready`=1 and `shift_en`=0. On `cfg_valid` it latches the word and goes to SHIFT. Otherwise it stays, and the source holds its data.
- SHIFT: `shift_en`=1 for k = min(8, remaining data bits) cycles, `ccff_head`=word[b] for b=0..k-1. It then goes to FETCH if data bits remain, else DONE.
- Words needed = ceil(N/8). Unused upper bits of the last word are discarded, never shifted.
- Total shifts per load = N+8. The shift count c has width $clog2(N+9).
- Check: on each shift edge with N ≤ c ≤ N+7 (c = shifts completed before this edge), compare `ccff_tail` with MARKER[c-N]. Any mismatch sets the sticky `error`.
- Final mapping: data bit i (i-th data bit shifted) resides in flop N-1-i.
- DONE: `done`=1, `busy`=0, `error` held until the next `start` or reset.
- `start` while `busy` is ignored. `ccff_head`=0 whenever `shift_en`=0.
- `pReset` mid-load: all outputs drop to 0 immediately (async) and the state is IDLE. Chain contents are undefined and a new `start` is required.

## Timing
- `start` captured at edge E0. Marker shifts occur on E1..E8, and FETCH begins after E8.
- Word w accepted no earlier than E9+9w. Its shifts follow on the next k edges, so throughput is 9 cycles per full word with `cfg_valid` held high.
- N=64, no stalls: the last shift is at E80, and `done`=1, `busy`=0 after E80.
- `cfg_ready`, `shift_en`, `busy`, `done` and `error` are registered. No combinational path exists from `cfg_valid` to `cfg_ready`.
- `error` is updated on the same edge as the offending compare. It is final when `done` rises.

## Test plan
- N=64, bench model of a 64-flop chain, words 0x01..0x08 streamed with `cfg_valid`=1 → `done` after E80, `error`=0, 72 `shift_en` cycles, flop 63 = 1 (bit 0 of 0x01), flop 0 = 0 (bit 7 of 0x08).
- Broken chain: `ccff_tail` stuck at 0 → `done` after E80, `error`=1. Chain model 65 flops long (wrong N) → `error`=1.
- Random `cfg_valid` gaps (e.g. a 5-cycle stall before every word) → `shift_en`=0 during stalls, same final chain contents as test 1, `done` later by the total stall cycles, `error`=0.
- N=61 (set via `CHAIN_LEN`), 8 words of 0xFF → 69 shifts, last word contributes 5 bits, `error`=0, all 61 flops = 1.
- `pReset` pulsed at the 30th shift → all outputs 0 in the same cycle, state IDLE. A new `start` then completes a full load with `error`=0.
- `start` pulsed mid-load → ignored, load completes normally. `start` in DONE after an error load → `error`/`done` cleared, reload succeeds.
